image_line_streamer: RTL
========================

# image_line_streamer

- **Position:** directly downstream of the image read/processing stage.
- **Input:** that stage's two-pixel-per-beat RGB888 output, qualified by HSYNC. The input cannot be stalled.
- **Buffering:** each line is held in a ping-pong pair of line banks.
- **Output:** each buffered line is re-emitted as a one-pixel-per-cycle, 24-bit stream with ready/valid backpressure, plus end-of-line and end-of-frame markers.
- **Purpose:** decouples the bursty, unstallable source from a stallable consumer (display/DMA/file-writer path).

## Interface
Parameters:
- WIDTH, 512, pixels per line; must be even.
- HEIGHT, 512, lines per frame.

Ports:
- HCLK  in  1  clock, rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- VSYNC  in  1  frame-start indicator from upstream; high during start-up delay.
- HSYNC  in  1  beat qualifier; each HCLK cycle with HSYNC=1 carries two pixels.
- DATA_R0, DATA_G0, DATA_B0  in  8 each  even pixel of the beat.
- DATA_R1, DATA_G1, DATA_B1  in  8 each  odd pixel of the beat.
- O_PIXEL  out  24  {R,G,B}, R in [23:16].
- O_VALID  out  1  O_PIXEL valid.
- O_READY  in  1  consumer accepts when O_VALID & O_READY.
- O_EOL  out  1  marks the last pixel of a line (pixel WIDTH-1).
- O_EOF  out  1  marks the last pixel of line HEIGHT-1.
- frame_done  out  1  one-cycle pulse after the EOF pixel is accepted.
- overflow  out  1  sticky; an input line was dropped.

## Operation
**Storage**
- Two banks, each WIDTH/2 words × 48 bits.
- Word format: {R0,G0,B0,R1,G1,B1}.
- Synchronous write and synchronous (registered) read.

**Write side**
- wbank (1 bit) selects the target bank; wptr runs 0..WIDTH/2-1.
- Each HSYNC beat writes word wptr of wbank, then increments wptr.
- At wptr == WIDTH/2-1:
  - wptr wraps to 0;
  - full[wbank] is set;
  - wbank toggles.
- Line-start check, on a beat with wptr == 0:
  - if full[wbank] = 1 and the bank is not being freed in the same cycle, the whole line is dropped;
  - a drop flag is held for WIDTH/2 beats;
  - no write occurs, full is not set, and wbank does not toggle;
  - overflow is set.
- A free in the same cycle takes precedence: the line is accepted.
- VSYNC = 1 forces wptr = 0 and clears the drop flag. It does not affect banks already full or the drain in progress.
- HSYNC deasserting mid-line does not reset wptr. Beats simply resume counting.

**Read side**
- rbank alternates 0, 1, 0, … in fill order.
- Read-side state machine:
  - R_IDLE: when full[rbank] = 1, issue a read of word 0 → R_PIX0.
  - R_PIX0: O_PIXEL = even pixel, O_VALID = 1. On accept → R_PIX1.
  - R_PIX1: O_PIXEL = odd pixel, O_VALID = 1. Read of the next word is issued in this state, so a following R_PIX0 carries no bubble.
    - On accept, if not the last word → R_PIX0.
    - On accept, if the last word: clear full[rbank], toggle rbank → R_IDLE.
- O_EOL = 1 in R_PIX1 of word WIDTH/2-1.
- Output line counter oline runs 0..HEIGHT-1 and increments on EOL accept, wrapping to 0 after HEIGHT-1.
- O_EOF = O_EOL & (oline == HEIGHT-1).
- Dropped lines are never output and never counted.
- O_PIXEL, O_EOL and O_EOF are held stable while O_VALID & !O_READY. O_VALID never drops without an accept.

**Reset**
- Async; all state is cleared.
- Outputs O_PIXEL=0, O_VALID=0, O_EOL=0, O_EOF=0, frame_done=0, overflow=0.
- full = 00, wbank = rbank = 0, wptr = 0, oline = 0, state R_IDLE.
- Reset mid-line discards all buffered data.
- overflow clears only on reset.

## Timing
- **Fill:** the last beat of a line at cycle t sets full at t+1.
- **Latency:** R_IDLE sees full at t+1, issues the read, and O_VALID = 1 at t+2 with pixel 0.
- **Throughput:** 1 pixel/cycle with O_READY held high, i.e. WIDTH cycles per line plus 1 cycle from R_IDLE.
- **No-overflow condition:** sustained O_READY = 1 with upstream period ≥ WIDTH/2 + HSYNC gap ≥ WIDTH+1 cycles (512-wide, 480-cycle gap: 736 ≥ 513).
- **Free timing:** full is cleared at the edge where the last pixel is accepted. A line start in that same cycle targeting that bank is accepted.
- **frame_done:** asserted exactly 1 cycle after the EOF accept edge, for 1 cycle.

## Test plan
1. **Reset values.** Assert reset mid-stream. Required: all outputs 0 and the first full line after release is output from pixel 0. Release reset, then send one line with pixel n = {n,n+1,n+2}, O_READY = 1. Required: O_VALID at t+2, pixels 0..511 in order, O_EOL only on pixel 511.
2. **Backpressure hold.** Toggle O_READY 1/0 pseudo-randomly. Required: pixel sequence unchanged, and O_PIXEL stable while O_VALID & !O_READY.
3. **Frame markers.** Run a full frame (HEIGHT = 4 override, WIDTH = 8). Required: O_EOF on line 3 pixel 7, frame_done pulse 1 cycle later, and oline wraps (next line has no O_EOF).
4. **Overflow/drop.** Hold O_READY = 0 and send 3 lines. Required: lines 0 and 1 buffered, line 2 dropped, overflow = 1. Then release O_READY. Required: exactly lines 0 and 1 output, and overflow stays 1.
5. **Simultaneous free and line start.** With both banks full, a line starts in the same cycle the EOL of the draining bank is accepted. Required: line accepted and no overflow.
6. **VSYNC mid-line.** Pulse VSYNC after 3 beats of a line. Required: wptr restarts, and the next WIDTH/2 beats form one complete line.

Source files
------------

// File: rtl/image_line_streamer.sv
// ---------------------------------------------------------------------------
// image_line_streamer
//
// Sits directly behind the image read/processing stage. That stage delivers
// two RGB888 pixels per HSYNC beat and cannot be stalled. Each incoming line
// is captured into one of two ping-pong line banks. Completed lines are then
// replayed as a one-pixel-per-cycle, 24-bit ready/valid stream that a
// stallable consumer (display, DMA, file writer) can throttle.
//
// If both banks are still occupied when a new line starts, that whole line is
// discarded and the sticky overflow flag is raised.
//
// Parameters
//   WIDTH   pixels per line (must be even, two pixels per beat)
//   HEIGHT  lines per frame
//
// Ports
//   HCLK            clock, rising edge
//   HRESETn         asynchronous active-low reset
//   VSYNC           frame-start indicator, restarts the write pointer
//   HSYNC           beat qualifier, each high cycle carries two pixels
//   DATA_R0/G0/B0   even pixel of the beat
//   DATA_R1/G1/B1   odd pixel of the beat
//   O_PIXEL         output pixel {R,G,B}, R in [23:16]
//   O_VALID         O_PIXEL holds a valid pixel
//   O_READY         consumer accepts when O_VALID & O_READY
//   O_EOL           last pixel of a line
//   O_EOF           last pixel of the last line of a frame
//   frame_done      one-cycle pulse after the EOF pixel is accepted
//   overflow        sticky, an input line was dropped
// ---------------------------------------------------------------------------
module image_line_streamer #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        VSYNC,
    input  logic        HSYNC,
    input  logic [7:0]  DATA_R0,
    input  logic [7:0]  DATA_G0,
    input  logic [7:0]  DATA_B0,
    input  logic [7:0]  DATA_R1,
    input  logic [7:0]  DATA_G1,
    input  logic [7:0]  DATA_B1,
    output logic [23:0] O_PIXEL,
    output logic        O_VALID,
    input  logic        O_READY,
    output logic        O_EOL,
    output logic        O_EOF,
    output logic        frame_done,
    output logic        overflow
);

    localparam int WORDS = WIDTH / 2;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_PIX0 = 2'd1,
        R_PIX1 = 2'd2
    } rd_state_t;

    // Line storage: two banks, one 48-bit word per input beat,
    // word format {R0,G0,B0,R1,G1,B1}.
    logic [47:0] mem [0:1][0:WORDS-1];

    // Write side state
    logic          wbank;
    logic [AW-1:0] wptr;
    logic          drop;
    logic [1:0]    full;
    logic [1:0]    full_next;

    // Read side state
    rd_state_t     state;
    rd_state_t     state_next;
    logic          rbank;
    logic [AW-1:0] rptr;
    logic [LW-1:0] oline;
    logic [47:0]   rdata;

    // Combinational control
    logic          line_start;
    logic          bank_busy;
    logic          drop_beat;
    logic          wr_en;
    logic          line_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          free_line;
    logic          accept;

    // -----------------------------------------------------------------------
    // Write-side decisions.
    // A line is accepted or rejected once, on its first beat. A bank that is
    // being freed by the reader in this very cycle counts as available, so a
    // line starting on the drain's last accept is not lost. Rejected lines
    // still walk wptr through a full line so the next line lines up.
    // -----------------------------------------------------------------------
    always_comb begin
        line_start = HSYNC && !VSYNC && (wptr == '0);
        bank_busy  = full[wbank] && !(free_line && (rbank == wbank));
        drop_beat  = line_start ? bank_busy : drop;
        wr_en      = HSYNC && !VSYNC && !drop_beat;
        line_done  = wr_en && (wptr == LAST_WORD);
    end

    // -----------------------------------------------------------------------
    // Write pointer, bank select, drop flag and sticky overflow.
    // VSYNC only restarts the line position; banks already full keep their
    // data and the reader keeps draining.
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wbank    <= 1'b0;
            wptr     <= '0;
            drop     <= 1'b0;
            overflow <= 1'b0;
        end else if (VSYNC) begin
            wptr <= '0;
            drop <= 1'b0;
        end else if (HSYNC) begin
            if (wptr == LAST_WORD) begin
                wptr <= '0;
                drop <= 1'b0;
                if (!drop_beat) begin
                    wbank <= ~wbank;
                end
            end else begin
                wptr <= wptr + AW'(1);
                drop <= drop_beat;
            end
            if (line_start && bank_busy) begin
                overflow <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Bank occupancy. The reader's release is applied first so that a bank
    // freed and refilled in one cycle (only possible for single-word lines)
    // ends up marked full.
    // -----------------------------------------------------------------------
    always_comb begin
        full_next = full;
        if (free_line) begin
            full_next[rbank] = 1'b0;
        end
        if (line_done) begin
            full_next[wbank] = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            full <= 2'b00;
        end else begin
            full <= full_next;
        end
    end

    // -----------------------------------------------------------------------
    // Line bank write port. Contents are not reset; the full flags decide
    // what is meaningful, so a reset effectively discards buffered lines.
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem[wbank][wptr] <= {DATA_R0, DATA_G0, DATA_B0,
                                 DATA_R1, DATA_G1, DATA_B1};
        end
    end

    // -----------------------------------------------------------------------
    // Read-side state machine: next state and stream outputs.
    // The next word is fetched only when the odd pixel is accepted, so rdata
    // (and hence O_PIXEL) cannot change while the consumer stalls, and the
    // following even pixel follows without a bubble.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        O_VALID    = 1'b0;
        O_PIXEL    = 24'd0;
        O_EOL      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = rptr;
        free_line  = 1'b0;
        accept     = 1'b0;

        case (state)
            R_IDLE: begin
                if (full[rbank]) begin
                    rd_en      = 1'b1;
                    rd_addr    = '0;
                    state_next = R_PIX0;
                end
            end

            R_PIX0: begin
                O_VALID = 1'b1;
                O_PIXEL = rdata[47:24];
                accept  = O_READY;
                if (O_READY) begin
                    state_next = R_PIX1;
                end
            end

            R_PIX1: begin
                O_VALID = 1'b1;
                O_PIXEL = rdata[23:0];
                O_EOL   = (rptr == LAST_WORD);
                accept  = O_READY;
                if (O_READY) begin
                    if (rptr == LAST_WORD) begin
                        free_line  = 1'b1;
                        state_next = R_IDLE;
                    end else begin
                        rd_en      = 1'b1;
                        rd_addr    = rptr + AW'(1);
                        state_next = R_PIX0;
                    end
                end
            end

            default: begin
                state_next = R_IDLE;
            end
        endcase
    end

    assign O_EOF = O_EOL && (oline == LAST_LINE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= R_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Read pointer, bank alternation, output line count and frame pulse.
    // Only lines that were actually emitted advance oline.
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rptr       <= '0;
            rbank      <= 1'b0;
            oline      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && O_EOF;
            if (rd_en) begin
                rptr <= rd_addr;
            end
            if (free_line) begin
                rbank <= ~rbank;
            end
            if (accept && O_EOL) begin
                oline <= (oline == LAST_LINE) ? '0 : oline + LW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered read port feeding the output mux.
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rdata <= 48'd0;
        end else if (rd_en) begin
            rdata <= mem[rbank][rd_addr];
        end
    end

endmodule
